instr_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of the miniRV program counter: samples pc_in,

---
 rtl/instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly after the program counter. It samples pc_in
// and issues one instruction-memory request per instruction. It then holds the
// returned word until the decoder accepts it. The opcode of the held word is
// fed back to the PC, so JALR and sequential decisions are only taken on words
// that have actually been fetched.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   defined   - a 5-bit counter runs while waiting for read data. After
//               TIMEOUT_CYCLES WAIT cycles with no response, a NOP is
//               substituted and timeout_err is raised. The late response for
//               that request is dropped when it arrives.
//   undefined - WAIT lasts until read data arrives; timeout_err is tied 0.
//
// Handshakes:
//   imem side : a request is transferred on a cycle where imem_req && imem_ready.
//               imem_addr is stable from REQ entry until that cycle. Exactly
//               one imem_rvalid pulse is expected per transferred request. It
//               may arrive in the same cycle (zero-wait) or later. rvalid in
//               any other situation is ignored.
//   decoder   : instr/instr_pc/opcode/err flags are valid and stable while
//               instr_valid is 1. The word is consumed on a cycle where
//               instr_valid && instr_ready. instr_ready without instr_valid
//               has no effect.
//
// Ports:
//   clk           in   1   clock, rising edge
//   reset         in   1   synchronous active-low reset
//   pc_in         in   32  fetch address from program counter
//   imem_req      out  1   request valid to instruction memory
//   imem_addr     out  32  request address (pc_in captured on REQ entry)
//   imem_ready    in   1   memory accepts request this cycle
//   imem_rvalid   in   1   read data valid
//   imem_rdata    in   32  read data
//   instr_valid   out  1   held instruction valid to decoder
//   instr_ready   in   1   decoder accepts held instruction
//   instr         out  32  held instruction
//   instr_pc      out  32  address the held instruction came from
//   opcode        out  7   instr[6:0] while instr_valid, else OP-IMM (7'b0010011)
//   misalign_err  out  1   held word is a NOP substituted for a misaligned pc
//   timeout_err   out  1   held word is a NOP substituted after a timeout
//   dbg_state_o   out  2   current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [6:0] OPCODE_IDLE = 7'b0010011;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        mis_q, mis_d;
    logic        aligned;
    logic        rsp_valid;

`ifdef FETCH_TIMEOUT_EN
    logic [4:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    // Set when a request timed out. The next rvalid belongs to that abandoned
    // request and must not be taken as the response to a newer one.
    logic        drop_q, drop_d;

    assign rsp_valid = imem_rvalid && !drop_q;
`else
    // The timeout length only matters when the counter is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign rsp_valid = imem_rvalid;
`endif

    assign aligned = (addr_q[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'h0;
            mis_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= 5'd0;
            to_q    <= 1'b0;
            drop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            drop_q  <= drop_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
`ifdef FETCH_TIMEOUT_EN
        to_d    = to_q;
        // The counter is held at zero outside WAIT, so it starts from zero
        // on every WAIT entry.
        cnt_d   = 5'd0;
        drop_d  = drop_q;
        if (drop_q && imem_rvalid) begin
            drop_d = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = pc_in;
            end

            S_REQ: begin
                if (!aligned) begin
                    // The request is never issued. The NOP goes straight to the decoder.
                    state_d = S_HOLD;
                    instr_d = NOP_INSTR;
                    ipc_d   = addr_q;
                    mis_d   = 1'b1;
                end else if (imem_ready) begin
                    if (rsp_valid) begin
                        state_d = S_HOLD;
                        instr_d = imem_rdata;
                        ipc_d   = addr_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (rsp_valid) begin
                    state_d = S_HOLD;
                    instr_d = imem_rdata;
                    ipc_d   = addr_q;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == 5'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    instr_d = NOP_INSTR;
                    ipc_d   = addr_q;
                    to_d    = 1'b1;
                    drop_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
`endif
            end

            S_HOLD: begin
                if (instr_ready) begin
                    state_d = S_REQ;
                    addr_d  = pc_in;
                    mis_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req     = (state_q == S_REQ) && aligned;
        imem_addr    = addr_q;
        instr_valid  = (state_q == S_HOLD);
        instr        = instr_q;
        instr_pc     = ipc_q;
        // When nothing is held, the PC sees a harmless OP-IMM opcode, so it
        // never takes a JALR decision on stale data.
        opcode       = (state_q == S_HOLD) ? instr_q[6:0] : OPCODE_IDLE;
        misalign_err = mis_q;
`ifdef FETCH_TIMEOUT_EN
        timeout_err  = to_q;
`else
        timeout_err  = 1'b0;
`endif
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        misalign_err;
    logic        timeout_err;
    logic [1:0]  dbg_state_o;

    int tests;
    int fails;

    instr_fetch_unit #(.TIMEOUT_CYCLES(16), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .opcode       (opcode),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Advance one cycle. Sampling and driving happen 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
        tests++; if (instr !== NOP) begin fails++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        tests++; if ({misalign_err, timeout_err} !== 2'b00) begin fails++; $display("FAIL rst_errs: got %b want 00", {misalign_err, timeout_err}); end
        tests++; if (opcode !== 7'b0010011) begin fails++; $display("FAIL rst_opcode: got %b want 0010011", opcode); end
        // Release: cycle 1 is IDLE, cycle 2 issues the request.
        pc_in = 32'h100;
        reset = 1'b1;
        tests++; if (dbg_state_o !== ST_IDLE || imem_req !== 1'b0) begin fails++; $display("FAIL rel_cycle1: state %0d req %0b want IDLE/0", dbg_state_o, imem_req); end
        cyc();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rel_cycle2: req %0b addr %h want 1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        cyc();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hFFFF_FFFF;
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL zw_valid: got %0b want 1", instr_valid); end
        tests++; if (instr !== 32'h0050_0093) begin fails++; $display("FAIL zw_instr: got %h want 00500093", instr); end
        tests++; if (instr_pc !== 32'h100) begin fails++; $display("FAIL zw_instr_pc: got %h want 00000100", instr_pc); end
        tests++; if (opcode !== 7'b0010011) begin fails++; $display("FAIL zw_opcode: got %b want 0010011", opcode); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL zw_req_in_hold: got %0b want 0", imem_req); end
    endtask

    task automatic test_wait_hold();
        pc_in       = 32'h200;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        pc_in       = 32'h204;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL wh_req: req %0b addr %h want 1/00000200", imem_req, imem_addr); end
        // Memory not ready: the address must stay put even though pc_in moved.
        cyc();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL wh_addr_stable: req %0b addr %h want 1/00000200", imem_req, imem_addr); end
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        tests++; if (dbg_state_o !== ST_WAIT || imem_req !== 1'b0) begin fails++; $display("FAIL wh_wait: state %0d req %0b want WAIT/0", dbg_state_o, imem_req); end
        cyc();
        cyc();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wh_wait_valid: got %0b want 0", instr_valid); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_8463;
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h1234_5678;
        pc_in       = 32'h300;
        for (int i = 0; i < 4; i++) begin
            // A stray rvalid during HOLD must not disturb the held word.
            imem_rvalid = (i == 1);
            tests++; if (instr_valid !== 1'b1 || instr !== 32'h0020_8463 || instr_pc !== 32'h200 || opcode !== 7'h63) begin
                fails++; $display("FAIL wh_hold_stable[%0d]: valid %0b instr %h pc %h op %h want 1/00208463/00000200/63", i, instr_valid, instr, instr_pc, opcode);
            end
            cyc();
        end
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h0020_8463) begin fails++; $display("FAIL wh_hold_after_stray: valid %0b instr %h", instr_valid, instr); end
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin fails++; $display("FAIL wh_next_req: req %0b addr %h valid %0b want 1/00000300/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_back_to_back();
        // Currently in REQ for 0x300. Two zero-wait fetches, one every 2 cycles.
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_8067;
        cyc();
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h0000_8067 || opcode !== 7'h67) begin fails++; $display("FAIL b2b_first: valid %0b instr %h op %h want 1/00008067/67", instr_valid, instr, opcode); end
        pc_in       = 32'h304;
        instr_ready = 1'b1;
        imem_rdata  = 32'h0010_0113;
        cyc();
        instr_ready = 1'b0;
        tests++; if (instr_valid !== 1'b0 || imem_addr !== 32'h304) begin fails++; $display("FAIL b2b_gap: valid %0b addr %h want 0/00000304", instr_valid, imem_addr); end
        cyc();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        tests++; if (instr !== 32'h0010_0113 || instr_pc !== 32'h304 || instr_valid !== 1'b1) begin fails++; $display("FAIL b2b_second: instr %h pc %h valid %0b want 00100113/00000304/1", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_misalign();
        pc_in       = 32'h102;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        imem_ready  = 1'b1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mis_no_req: got %0b want 0", imem_req); end
        cyc();
        imem_ready = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== NOP || misalign_err !== 1'b1) begin fails++; $display("FAIL mis_hold: valid %0b instr %h mis %0b want 1/00000013/1", instr_valid, instr, misalign_err); end
        tests++; if (instr_pc !== 32'h102 || timeout_err !== 1'b0) begin fails++; $display("FAIL mis_pc: pc %h to %0b want 00000102/0", instr_pc, timeout_err); end
        pc_in       = 32'h400;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        tests++; if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin fails++; $display("FAIL mis_clear: mis %0b req %0b addr %h want 0/1/00000400", misalign_err, imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        tests++; if (dbg_state_o !== ST_WAIT) begin fails++; $display("FAIL rmw_in_wait: state %0d want WAIT", dbg_state_o); end
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        tests++; if (dbg_state_o !== ST_IDLE || instr_valid !== 1'b0) begin fails++; $display("FAIL rmw_idle: state %0d valid %0b want IDLE/0", dbg_state_o, instr_valid); end
        cyc();
        // The late response of the abandoned request arrives here.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin fails++; $display("FAIL rmw_late_dropped[%0d]: valid %0b req %0b want 0/1", i, instr_valid, imem_req); end
            cyc();
        end
        imem_ready = 1'b1;
        cyc();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_0093;
        cyc();
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0093 || instr_pc !== 32'h400) begin fails++; $display("FAIL rmw_fresh: valid %0b instr %h pc %h want 1/00100093/00000400", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_timeout();
        pc_in       = 32'h500;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        imem_ready  = 1'b1;
        cyc();
        imem_ready = 1'b0;
        // 16 WAIT cycles with no response.
        for (int i = 0; i < 16; i++) begin
            tests++; if (instr_valid !== 1'b0 || dbg_state_o !== ST_WAIT) begin fails++; $display("FAIL to_waiting[%0d]: valid %0b state %0d want 0/WAIT", i, instr_valid, dbg_state_o); end
            cyc();
        end
`ifdef FETCH_TIMEOUT_EN
        tests++; if (instr_valid !== 1'b1 || instr !== NOP || timeout_err !== 1'b1 || instr_pc !== 32'h500) begin
            fails++; $display("FAIL to_nop: valid %0b instr %h to %0b pc %h want 1/00000013/1/00000500", instr_valid, instr, timeout_err, instr_pc);
        end
        // Late response for the timed-out request arrives during HOLD.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        cyc();
        imem_rvalid = 1'b0;
        pc_in       = 32'h504;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        tests++; if (timeout_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h504) begin fails++; $display("FAIL to_clear: to %0b req %0b addr %h want 0/1/00000504", timeout_err, imem_req, imem_addr); end
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0030_0193;
        cyc();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h0030_0193) begin fails++; $display("FAIL to_after: valid %0b instr %h want 1/00300193", instr_valid, instr); end
`else
        for (int i = 0; i < 20; i++) cyc();
        tests++; if (instr_valid !== 1'b0 || timeout_err !== 1'b0 || dbg_state_o !== ST_WAIT) begin
            fails++; $display("FAIL to_disabled: valid %0b to %0b state %0d want 0/0/WAIT", instr_valid, timeout_err, dbg_state_o);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0030_0193;
        cyc();
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h0030_0193 || instr_pc !== 32'h500 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL to_long_wait: valid %0b instr %h pc %h to %0b want 1/00300193/00000500/0", instr_valid, instr, instr_pc, timeout_err);
        end
`endif
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b0;
        pc_in       = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        #1;
        test_reset();
        test_zero_wait();
        test_wait_hold();
        test_back_to_back();
        test_misalign();
        test_reset_mid_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
